// File: rtl/ac_rle_gr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ac_rle_gr_scheduler_if
// Brief    : Coefficient input and Golomb-Rice token output bundle for the
//            AC run/level scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface ac_rle_gr_scheduler_if #(
  parameter int COEF_W = 16
);
  // Upstream coefficient stream
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_coef;
  logic                     in_last;

  // Downstream token stream to the coder / packer
  logic                     gr_valid;
  logic                     gr_ready;
  logic [2:0]               gr_k;
  logic [31:0]              gr_val;
  logic                     gr_is_ac_level;
  logic                     gr_is_minus;

  // Environment side: feeds coefficients, consumes tokens
  modport master (
    output in_valid, in_coef, in_last, gr_ready,
    input  in_ready, gr_valid, gr_k, gr_val, gr_is_ac_level, gr_is_minus
  );

  // Scheduler side
  modport slave (
    input  in_valid, in_coef, in_last, gr_ready,
    output in_ready, gr_valid, gr_k, gr_val, gr_is_ac_level, gr_is_minus
  );
endinterface
`default_nettype wire

// File: rtl/ac_rle_gr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ac_rle_gr_scheduler
// Brief    : Collapses zero runs of a scanned AC block into alternating run /
//            level tokens for a Golomb-Rice coder, with adaptive k selection.
// Revision : 1.0 - initial release
// ============================================================================
module ac_rle_gr_scheduler #(
  parameter int COEF_W    = 16,
  parameter int BLOCK_LEN = 63,
  parameter int K_MAX     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ac_rle_gr_scheduler_if.slave bus,
  output logic                 block_done,
  output logic                 proto_err
);

  localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int RUN_W = IDX_W + 1;
  // Magnitude is kept one bit wider so |most negative| never wraps
  localparam int MAG_W = COEF_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] EMIT_RUN = 2'd1;
  localparam logic [1:0] EMIT_LVL = 2'd2;

  logic [1:0]        state;
  logic [RUN_W-1:0]  run;
  logic [IDX_W-1:0]  idx;
  logic [RUN_W-1:0]  prev_run;
  logic [COEF_W-1:0] prev_lvl;
  logic [MAG_W-1:0]  mag;
  logic              sgn;
  logic              last_q;

  logic              tok_valid;
  logic [2:0]        tok_k;
  logic [31:0]       tok_val;
  logic              tok_is_level;
  logic              tok_is_minus;

  logic              accept;
  logic              at_last_idx;
  logic              eff_last;
  logic              idx_mismatch;
  logic              coef_zero;
  logic [MAG_W-1:0]  coef_ext;
  logic [MAG_W-1:0]  coef_abs;
  logic [MAG_W-1:0]  mag_next;
  logic [MAG_W-1:0]  lvl_inc;
  logic [COEF_W-1:0] lvl_sat;

  // Rice parameter from the magnitude of the previous run or level, capped
  function automatic logic [2:0] ksel(input logic [31:0] x);
    logic [2:0] k;
    if (x < 32'd2)       k = 3'd0;
    else if (x < 32'd4)  k = 3'd1;
    else if (x < 32'd8)  k = 3'd2;
    else if (x < 32'd16) k = 3'd3;
    else                 k = 3'd4;
    if (k > 3'(K_MAX)) k = 3'(K_MAX);
    return k;
  endfunction

  assign bus.in_ready       = (state == SCAN);
  assign bus.gr_valid       = tok_valid;
  assign bus.gr_k           = tok_k;
  assign bus.gr_val         = tok_val;
  assign bus.gr_is_ac_level = tok_is_level;
  assign bus.gr_is_minus    = tok_is_minus;

  // Accept decode, block-end detection and magnitude arithmetic
  always_comb begin
    accept       = bus.in_valid & (state == SCAN);
    at_last_idx  = (idx == LAST_IDX);
    // A block closes at the last index even when in_last is missing
    eff_last     = bus.in_last | at_last_idx;
    idx_mismatch = bus.in_last ^ at_last_idx;
    coef_zero    = (bus.in_coef == '0);
    coef_ext     = {bus.in_coef[COEF_W-1], bus.in_coef};
    coef_abs     = bus.in_coef[COEF_W-1] ? (~coef_ext + MAG_W'(1)) : coef_ext;
    mag_next     = coef_abs - MAG_W'(1);
    lvl_inc      = mag + MAG_W'(1);
    lvl_sat      = lvl_inc[COEF_W] ? {COEF_W{1'b1}} : lvl_inc[COEF_W-1:0];
  end

  // Scheduler FSM: scan zeros, then emit run token followed by level token
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SCAN;
      run          <= '0;
      idx          <= '0;
      prev_run     <= RUN_W'(4);
      prev_lvl     <= COEF_W'(1);
      mag          <= '0;
      sgn          <= 1'b0;
      last_q       <= 1'b0;
      tok_valid    <= 1'b0;
      tok_k        <= 3'd0;
      tok_val      <= 32'd0;
      tok_is_level <= 1'b0;
      tok_is_minus <= 1'b0;
      block_done   <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        SCAN: begin
          if (accept) begin
            idx    <= idx + IDX_W'(1);
            last_q <= eff_last;
            if (idx_mismatch) proto_err <= 1'b1;
            if (coef_zero) begin
              if (eff_last) begin
                // Trailing zeros are dropped; only the block end is signalled
                block_done <= 1'b1;
                run        <= '0;
                idx        <= '0;
                prev_run   <= RUN_W'(4);
                prev_lvl   <= COEF_W'(1);
              end else begin
                run <= run + RUN_W'(1);
              end
            end else begin
              mag          <= mag_next;
              sgn          <= bus.in_coef[COEF_W-1];
              tok_valid    <= 1'b1;
              tok_val      <= 32'(run);
              tok_is_level <= 1'b0;
              tok_is_minus <= 1'b0;
              tok_k        <= ksel(32'(prev_run));
              state        <= EMIT_RUN;
            end
          end
        end

        EMIT_RUN: begin
          if (bus.gr_ready) begin
            tok_val      <= 32'(mag);
            tok_is_level <= 1'b1;
            tok_is_minus <= sgn;
            tok_k        <= ksel(32'(prev_lvl));
            prev_run     <= run;
            state        <= EMIT_LVL;
          end
        end

        EMIT_LVL: begin
          if (bus.gr_ready) begin
            tok_valid <= 1'b0;
            run       <= '0;
            state     <= SCAN;
            if (last_q) begin
              block_done <= 1'b1;
              idx        <= '0;
              prev_run   <= RUN_W'(4);
              prev_lvl   <= COEF_W'(1);
            end else begin
              prev_lvl <= lvl_sat;
            end
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ac_rle_gr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_rle_gr_scheduler
// Brief    : Directed self-checking bench for the AC run/level scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ac_rle_gr_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic block_done;
  logic proto_err;

  int total = 0;
  int bad   = 0;

  ac_rle_gr_scheduler_if #(.COEF_W(16)) bus ();

  ac_rle_gr_scheduler #(
    .COEF_W   (16),
    .BLOCK_LEN(63),
    .K_MAX    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .block_done(block_done),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, gr_valid, gr_k, gr_val, gr_is_ac_level, gr_is_minus}
  function automatic logic [63:0] tok();
    return 64'({bus.in_ready, bus.gr_valid, bus.gr_k, bus.gr_val,
                bus.gr_is_ac_level, bus.gr_is_minus});
  endfunction

  function automatic logic [63:0] exp_tok(input logic rdy, input logic v, input logic [2:0] k,
                                          input logic [31:0] val, input logic ac, input logic mn);
    return 64'({rdy, v, k, val, ac, mn});
  endfunction

  task automatic zeros(input int n, input logic last_end);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_coef  = 16'sd0;
      bus.in_last  = last_end && (i == n - 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Send one nonzero coefficient with gr_ready high and check both tokens
  task automatic send_nz(input string tag, input logic [15:0] c,
                         input logic [31:0] rval, input logic [2:0] rk,
                         input logic [31:0] lval, input logic lmn, input logic [2:0] lk);
    bus.in_valid = 1'b1;
    bus.in_coef  = c;
    bus.in_last  = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_run"}, tok(), exp_tok(1'b0, 1'b1, rk, rval, 1'b0, 1'b0));
    tick();
    chk({tag, "_lvl"}, tok(), exp_tok(1'b0, 1'b1, lk, lval, 1'b1, lmn));
    tick();
    chk({tag, "_idle"}, 64'({bus.in_ready, bus.gr_valid}), 64'(2'b10));
  endtask

  initial begin
    int dcount;
    int gvcount;
    logic [63:0] snap;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_coef  = 16'sd0;
    bus.in_last  = 1'b0;
    bus.gr_ready = 1'b1;
    tick();
    tick();
    chk("reset_tok", tok(), exp_tok(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0));
    chk("reset_flags", 64'({block_done, proto_err}), 64'(2'b00));
    reset = 1'b0;

    // Block of 63 zeros: no tokens, one block_done right after last accept
    dcount  = 0;
    gvcount = 0;
    for (int i = 0; i < 63; i++) begin
      bus.in_valid = 1'b1;
      bus.in_coef  = 16'sd0;
      bus.in_last  = (i == 62);
      tick();
      if (block_done) dcount++;
      if (bus.gr_valid) gvcount++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("zblk_done_now", 64'(block_done), 64'd1);
    tick();
    chk("zblk_done_gone", 64'(block_done), 64'd0);
    chk("zblk_done_count", 64'(dcount), 64'd1);
    chk("zblk_no_tokens", 64'(gvcount), 64'd0);
    chk("zblk_proto", 64'(proto_err), 64'd0);

    // +1 then 62 zeros: run k=ksel(4)=2 val 0; level k=ksel(1)=0 val 0
    send_nz("plus1", 16'd1, 32'd0, 3'd2, 32'd0, 1'b0, 3'd0);
    zeros(62, 1'b1);
    chk("plus1_done", 64'({block_done, proto_err}), 64'(2'b10));
    tick();

    // 0,0,0,-5,0,2 then zeros: k adapts from previous run / level
    zeros(3, 1'b0);
    send_nz("m5", 16'hFFFB, 32'd3, 3'd2, 32'd4, 1'b1, 3'd0);
    zeros(1, 1'b0);
    send_nz("p2", 16'd2, 32'd1, 3'd1, 32'd1, 1'b0, 3'd2);
    zeros(57, 1'b1);
    chk("m5_done", 64'({block_done, proto_err}), 64'(2'b10));
    tick();

    // Backpressure during EMIT_RUN for 5 cycles
    bus.gr_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_coef  = 16'sd3;
    tick();
    bus.in_valid = 1'b0;
    snap = tok();
    chk("stall_first", snap, exp_tok(1'b0, 1'b1, 3'd2, 32'd0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", tok(), exp_tok(1'b0, 1'b1, 3'd2, 32'd0, 1'b0, 1'b0));
    end
    bus.gr_ready = 1'b1;
    tick();
    chk("stall_lvl", tok(), exp_tok(1'b0, 1'b1, 3'd0, 32'd2, 1'b1, 1'b0));
    tick();
    chk("stall_idle", 64'({bus.in_ready, bus.gr_valid}), 64'(2'b10));
    zeros(62, 1'b1);
    chk("stall_done", 64'({block_done, proto_err}), 64'(2'b10));
    tick();

    // Early in_last at idx 10: error, block closed, prediction state restored
    zeros(11, 1'b1);
    chk("early_last", 64'({block_done, proto_err}), 64'(2'b11));
    tick();
    send_nz("post_err", 16'hFFFB, 32'd0, 3'd2, 32'd4, 1'b1, 3'd0);
    send_nz("p20", 16'd20, 32'd0, 3'd0, 32'd19, 1'b0, 3'd2);
    send_nz("most_neg", 16'h8000, 32'd0, 3'd0, 32'd32767, 1'b1, 3'd4);
    zeros(60, 1'b0);
    chk("implicit_close", 64'(block_done), 64'd1);
    tick();

    // Reset while the level token is pending
    bus.in_valid = 1'b1;
    bus.in_coef  = 16'sd1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("pre_reset_lvl", 64'({bus.gr_valid, bus.gr_is_ac_level}), 64'(2'b11));
    bus.gr_ready = 1'b0;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    bus.gr_ready = 1'b1;
    chk("mid_reset", 64'({bus.in_ready, bus.gr_valid, block_done, proto_err}), 64'(4'b1000));

    // 63 zeros with no in_last: closed at last index and flagged
    zeros(63, 1'b0);
    chk("missing_last", 64'({block_done, proto_err}), 64'(2'b11));
    tick();
    chk("missing_last_pulse", 64'(block_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
